// File: rtl/t05_huff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : t05_huff_pkg
// Purpose  : Shared types and constants for the Huffman front end.
//            - flv_state_t : scan FSM state encoding for t05_find_least_value
//            - NUM_SYMBOLS : number of count-table entries
//            - COUNT_W     : width of one SRAM count word
//            - EOF_CHAR    : end-of-file marker character
// Revision : 1.0 - initial release
// ============================================================================
package t05_huff_pkg;

  localparam int         NUM_SYMBOLS = 256;
  localparam int         COUNT_W     = 32;
  localparam logic [7:0] EOF_CHAR    = 8'h1A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } flv_state_t;

endpackage : t05_huff_pkg
`default_nettype wire

// File: rtl/t05_min2_tracker.sv
`default_nettype none
// ============================================================================
// Module   : t05_min2_tracker
// Purpose  : Holds the two smallest counts offered so far, with their indices.
//            A candidate is considered only when 'load' is high; the caller is
//            responsible for filtering out zero counts. Strict unsigned '<'
//            keeps the earlier (lower) index on ties.
// Ports    :
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   clear       in   synchronous clear of all results (new scan)
//   load        in   offer (cand_idx, cand_cnt) for insertion
//   cand_idx    in   8       candidate index
//   cand_cnt    in   COUNT_W candidate count
//   least1_idx  out  8       index of smallest count
//   least1_cnt  out  COUNT_W smallest count
//   least2_idx  out  8       index of second smallest count
//   least2_cnt  out  COUNT_W second smallest count
//   found       out  2       number of valid slots (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module t05_min2_tracker #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [7:0]         cand_idx,
  input  logic [COUNT_W-1:0] cand_cnt,
  output logic [7:0]         least1_idx,
  output logic [COUNT_W-1:0] least1_cnt,
  output logic [7:0]         least2_idx,
  output logic [COUNT_W-1:0] least2_cnt,
  output logic [1:0]         found
);
  import t05_huff_pkg::*;

  logic take_first;
  logic take_second;

  // An empty slot always accepts; otherwise the candidate must be strictly
  // smaller than the occupant.
  always_comb begin
    take_first  = (found == 2'd0) || (cand_cnt < least1_cnt);
    take_second = !take_first && ((found < 2'd2) || (cand_cnt < least2_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      least1_idx <= 8'd0;
      least1_cnt <= '0;
      least2_idx <= 8'd0;
      least2_cnt <= '0;
      found      <= 2'd0;
    end else if (load) begin
      if (take_first) begin
        // Previous minimum slides down; while found==0 it is still (0,0),
        // which keeps the unused slot reading as zero.
        least2_idx <= least1_idx;
        least2_cnt <= least1_cnt;
        least1_idx <= cand_idx;
        least1_cnt <= cand_cnt;
      end else if (take_second) begin
        least2_idx <= cand_idx;
        least2_cnt <= cand_cnt;
      end
      if ((take_first || take_second) && (found != 2'd2)) begin
        found <= found + 2'd1;
      end
    end
  end

endmodule : t05_min2_tracker
`default_nettype wire

// File: rtl/t05_find_least_value.sv
`default_nettype none
// ============================================================================
// Module   : t05_find_least_value
// Purpose  : Scans the histogram count table in SRAM (one read per entry,
//            ascending index) and reports the two smallest non-zero counts
//            and their indices. One full pass per accepted 'start'.
// Config   : T05_FLV_NONZERO_COUNT_EN adds output nonzero_cnt[8:0], the number
//            of non-zero entries seen during the last scan.
// Ports    :
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   start        in   begin a scan (sampled in IDLE only)
//   sram_rdata   in   COUNT_W read data, valid with sram_ack
//   sram_ack     in   read completion, honoured only while rd_en=1
//   rd_en        out  read request
//   hist_addr    out  8       table index being read
//   least1_idx   out  8       index of smallest non-zero count
//   least1_cnt   out  COUNT_W smallest non-zero count
//   least2_idx   out  8       index of second smallest non-zero count
//   least2_cnt   out  COUNT_W second smallest non-zero count
//   found        out  2       number of valid results (0..2)
//   busy         out  scan in progress
//   done         out  one-cycle pulse at scan end
//   nonzero_cnt  out  9       non-zero entries seen (optional)
// Revision : 1.0 - initial release
// ============================================================================
module t05_find_least_value #(
  parameter int NUM_SYMBOLS = 256,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] sram_rdata,
  input  logic               sram_ack,
  output logic               rd_en,
  output logic [7:0]         hist_addr,
  output logic [7:0]         least1_idx,
  output logic [COUNT_W-1:0] least1_cnt,
  output logic [7:0]         least2_idx,
  output logic [COUNT_W-1:0] least2_cnt,
  output logic [1:0]         found,
  output logic               busy,
  output logic               done
`ifdef T05_FLV_NONZERO_COUNT_EN
  ,
  output logic [8:0]         nonzero_cnt
`endif
);
  import t05_huff_pkg::*;

  localparam logic [7:0] LAST_ADDR = 8'(NUM_SYMBOLS - 1);

  flv_state_t         state;
  flv_state_t         next_state;
  logic [COUNT_W-1:0] cap_cnt;
  logic               accept;
  logic               last_entry;
  logic               load;

  assign accept     = (state == ST_IDLE) && start;
  assign last_entry = (hist_addr == LAST_ADDR);
  assign load       = (state == ST_CMP) && (cap_cnt != '0);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start)    next_state = ST_REQ;
      ST_REQ:  if (sram_ack) next_state = ST_CMP;
      ST_CMP:  next_state = last_entry ? ST_DONE : ST_REQ;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    rd_en = (state == ST_REQ);
    busy  = (state != ST_IDLE);
    done  = (state == ST_DONE);
  end

  // ---------------- address and read-data capture ----------------
  // The address only moves in CMP, so it is stable for the whole REQ phase
  // regardless of how long the SRAM takes to acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_addr <= 8'd0;
      cap_cnt   <= '0;
    end else begin
      if (accept) begin
        hist_addr <= 8'd0;
      end else if ((state == ST_CMP) && !last_entry) begin
        hist_addr <= hist_addr + 8'd1;
      end
      if ((state == ST_REQ) && sram_ack) begin
        cap_cnt <= sram_rdata;
      end
    end
  end

  // ---------------- two-minimum tracker ----------------
  t05_min2_tracker #(
    .COUNT_W (COUNT_W)
  ) u_min2 (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .load       (load),
    .cand_idx   (hist_addr),
    .cand_cnt   (cap_cnt),
    .least1_idx (least1_idx),
    .least1_cnt (least1_cnt),
    .least2_idx (least2_idx),
    .least2_cnt (least2_cnt),
    .found      (found)
  );

`ifdef T05_FLV_NONZERO_COUNT_EN
  // ---------------- optional non-zero entry counter ----------------
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      nonzero_cnt <= 9'd0;
    end else if (load) begin
      nonzero_cnt <= nonzero_cnt + 9'd1;
    end
  end
`endif

endmodule : t05_find_least_value
`default_nettype wire

// File: tb/tb_t05_find_least_value.sv
`default_nettype none
// ============================================================================
// Module   : tb_t05_find_least_value
// Purpose  : Directed self-checking bench for t05_find_least_value. A small
//            SRAM model answers reads with zero or random 0..3 cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t05_find_least_value;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] sram_rdata;
  logic          sram_ack;
  logic          rd_en;
  logic [7:0]    hist_addr;
  logic [7:0]    least1_idx;
  logic [CW-1:0] least1_cnt;
  logic [7:0]    least2_idx;
  logic [CW-1:0] least2_cnt;
  logic [1:0]    found;
  logic          busy;
  logic          done;
`ifdef T05_FLV_NONZERO_COUNT_EN
  logic [8:0]    nonzero_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  t05_find_least_value #(
    .NUM_SYMBOLS (256),
    .COUNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sram_rdata (sram_rdata),
    .sram_ack   (sram_ack),
    .rd_en      (rd_en),
    .hist_addr  (hist_addr),
    .least1_idx (least1_idx),
    .least1_cnt (least1_cnt),
    .least2_idx (least2_idx),
    .least2_cnt (least2_cnt),
    .found      (found),
    .busy       (busy),
    .done       (done)
`ifdef T05_FLV_NONZERO_COUNT_EN
    ,
    .nonzero_cnt(nonzero_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [CW-1:0] mem [256];
  bit            rand_lat = 1'b0;
  logic          spur     = 1'b0;
  int            lat      = 0;
  int            waitc    = 0;

  assign sram_rdata = mem[hist_addr];
  assign sram_ack   = spur | (rd_en && (waitc >= lat));

  always @(posedge clk) begin
    if (rd_en && sram_ack) begin
      waitc <= 0;
      lat   <= rand_lat ? int'($urandom_range(0, 3)) : 0;
    end else if (rd_en) begin
      waitc <= waitc + 1;
    end else begin
      waitc <= 0;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int   done_cnt  = 0;
  logic prev_req  = 1'b0;
  logic prev_ack  = 1'b0;
  logic [7:0] prev_addr = 8'd0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    // A pending request (no ack last cycle) must keep its address.
    if (prev_req && !prev_ack && rd_en === 1'b1)
      check("addr_stable", hist_addr, prev_addr);
    prev_req  = (rd_en === 1'b1);
    prev_ack  = (sram_ack === 1'b1);
    prev_addr = hist_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  // Pulse start, then run to done. Optionally re-pulse start at entry
  // pulse_at while the scan is active. cyc = cycles from first REQ to done.
  task automatic run_scan(input int pulse_at, input int limit, output int cyc);
    bit pulsed = 1'b0;
    int n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rd_en_after_start", rd_en, 1);
    check("busy_after_start", busy, 1);
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
      if (pulse_at >= 0 && !pulsed && hist_addr == pulse_at && busy === 1'b1) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_reached", done, 1);
    cyc = n;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic load_case1();
    clear_mem();
    mem[65] = 32'd2;
    mem[66] = 32'd1;
    mem[67] = 32'd1;
  endtask

  // ---------------- directed sequence ----------------
  int cyc;
  int dc;
  int n;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_addr", hist_addr, 0);
    check("rst_l1_idx", least1_idx, 0);
    check("rst_l1_cnt", least1_cnt, 0);
    check("rst_l2_idx", least2_idx, 0);
    check("rst_l2_cnt", least2_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ack with no request pending is ignored
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    check("spur_busy", busy, 0);
    check("spur_addr", hist_addr, 0);
    check("spur_found", found, 0);

    // Case 1: three small counts, zero-wait ack
    load_case1();
    dc = done_cnt;
    run_scan(-1, 3000, cyc);
    check("c1_cycles", cyc, 512);
    check("c1_l1_idx", least1_idx, 66);
    check("c1_l1_cnt", least1_cnt, 1);
    check("c1_l2_idx", least2_idx, 67);
    check("c1_l2_cnt", least2_cnt, 1);
    check("c1_found", found, 2);
    check("c1_done_pulses", done_cnt - dc, 1);
`ifdef T05_FLV_NONZERO_COUNT_EN
    check("c1_nonzero", nonzero_cnt, 3);
`endif
    repeat (4) @(negedge clk);
    check("c1_hold_l1_idx", least1_idx, 66);
    check("c1_hold_addr", hist_addr, 255);

    // Case 2: all zero
    clear_mem();
    dc = done_cnt;
    run_scan(-1, 3000, cyc);
    check("c2_found", found, 0);
    check("c2_l1_idx", least1_idx, 0);
    check("c2_l1_cnt", least1_cnt, 0);
    check("c2_l2_idx", least2_idx, 0);
    check("c2_l2_cnt", least2_cnt, 0);
    check("c2_done_pulses", done_cnt - dc, 1);
`ifdef T05_FLV_NONZERO_COUNT_EN
    check("c2_nonzero", nonzero_cnt, 0);
`endif

    // Case 3: single non-zero entry
    clear_mem();
    mem[26] = 32'd5;
    run_scan(-1, 3000, cyc);
    check("c3_l1_idx", least1_idx, 26);
    check("c3_l1_cnt", least1_cnt, 5);
    check("c3_l2_idx", least2_idx, 0);
    check("c3_l2_cnt", least2_cnt, 0);
    check("c3_found", found, 1);
`ifdef T05_FLV_NONZERO_COUNT_EN
    check("c3_nonzero", nonzero_cnt, 1);
`endif

    // Case 4: extreme counts at the table ends, random ack latency
    clear_mem();
    mem[0]   = 32'hFFFF_FFFF;
    mem[255] = 32'hFFFF_FFFE;
    rand_lat = 1'b1;
    run_scan(-1, 3000, cyc);
    rand_lat = 1'b0;
    check("c4_l1_idx", least1_idx, 255);
    check("c4_l1_cnt", least1_cnt, 64'hFFFF_FFFE);
    check("c4_l2_idx", least2_idx, 0);
    check("c4_l2_cnt", least2_cnt, 64'hFFFF_FFFF);
    check("c4_found", found, 2);
`ifdef T05_FLV_NONZERO_COUNT_EN
    check("c4_nonzero", nonzero_cnt, 2);
`endif
    @(negedge clk);

    // Case 5: reset while reading entry 100 aborts without done
    load_case1();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rd_en === 1'b1 && hist_addr == 8'd100) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("c5_reach_100", hist_addr, 100);
    check("c5_found_before_rst", found, 2);
    dc  = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("c5_rd_en", rd_en, 0);
    check("c5_busy", busy, 0);
    check("c5_done", done, 0);
    check("c5_addr", hist_addr, 0);
    check("c5_found", found, 0);
    check("c5_l1_idx", least1_idx, 0);
    check("c5_l1_cnt", least1_cnt, 0);
    check("c5_l2_idx", least2_idx, 0);
    check("c5_l2_cnt", least2_cnt, 0);
    repeat (5) @(negedge clk);
    check("c5_no_done", done_cnt - dc, 0);
    check("c5_still_idle", busy, 0);

    // Case 6: fresh start after abort completes normally
    dc = done_cnt;
    run_scan(-1, 3000, cyc);
    check("c6_cycles", cyc, 512);
    check("c6_l1_idx", least1_idx, 66);
    check("c6_l2_idx", least2_idx, 67);
    check("c6_found", found, 2);
    check("c6_done_pulses", done_cnt - dc, 1);

    // Case 7: start pulsed mid-scan is ignored
    clear_mem();
    mem[10]  = 32'd7;
    mem[200] = 32'd3;
    dc = done_cnt;
    run_scan(50, 3000, cyc);
    check("c7_cycles", cyc, 512);
    check("c7_l1_idx", least1_idx, 200);
    check("c7_l1_cnt", least1_cnt, 3);
    check("c7_l2_idx", least2_idx, 10);
    check("c7_l2_cnt", least2_cnt, 7);
    check("c7_done_pulses", done_cnt - dc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_t05_find_least_value
`default_nettype wire
